// File: rtl/multicycle_pkg.sv
// Shared types and constants for the multicycle RV32I control unit.
package multicycle_pkg;

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EX   = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_TRAP = 3'd5
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_SRL = 4'b1000;
  localparam logic [3:0] ALU_SLL = 4'b1001;
  localparam logic [3:0] ALU_XOR = 4'b1010;
  localparam logic [3:0] ALU_SRA = 4'b1100;

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

endpackage

// File: rtl/multicycle_alu_dec.sv
// Combinational instruction decoder: ALU operation plus an illegal flag
// for anything outside the supported RV32I subset.
module multicycle_alu_dec
  import multicycle_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  output logic [3:0] alu_ctrl,
  output logic       illegal
);

  logic r_alt;

  // For OP-IMM bit 30 is an immediate bit except on shifts, so it only
  // disqualifies R-type encodings that have no alternate form.
  assign r_alt = (opcode == OP_R) && funct7_5;

  // Map opcode/funct3/funct7[5] to ALU operation and legality.
  always_comb begin
    alu_ctrl = ALU_ADD;
    illegal  = 1'b0;
    case (opcode)
      OP_R, OP_IMM: begin
        case (funct3)
          3'b000: alu_ctrl = r_alt ? ALU_SUB : ALU_ADD;
          3'b001: begin alu_ctrl = ALU_SLL; illegal = funct7_5; end
          3'b010: begin alu_ctrl = ALU_SLT; illegal = r_alt; end
          3'b100: begin alu_ctrl = ALU_XOR; illegal = r_alt; end
          3'b101: alu_ctrl = funct7_5 ? ALU_SRA : ALU_SRL;
          3'b110: begin alu_ctrl = ALU_OR;  illegal = r_alt; end
          3'b111: begin alu_ctrl = ALU_AND; illegal = r_alt; end
          default: illegal = 1'b1;
        endcase
      end
      OP_LOAD, OP_STORE: begin
        alu_ctrl = ALU_ADD;
        illegal  = (funct3 != 3'b010);
      end
      OP_BRANCH: begin
        alu_ctrl = ALU_SUB;
        illegal  = (funct3[2:1] != 2'b00);
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32I control unit: IF/ID/EX/MEM/WB sequencing with memory
// wait states and an illegal-instruction trap.
// Optional MEM timeout trap enabled by defining MULTICYCLE_TIMEOUT_EN.
// Handshakes: a fetch completes on any cycle in IF with imem_ready=1, a data
// access completes on any cycle in MEM with dmem_ready=1; strobes stay high
// through that cycle and readies seen in other states are ignored.
module multicycle_ctrl
  import multicycle_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int RET_W          = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      instr,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  input  logic             Zero,
  output logic             imem_req,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             ALUSrc,
  output logic             MemToReg,
  output logic             RegWrite,
  output logic             loadPC,
  output logic             PCSrc,
  output logic [3:0]       ALUCtrl,
  output logic             trap,
  output logic [1:0]       trap_cause,
  output logic [RET_W-1:0] retired,
  output state_t           state
);

  state_t      next_state;
  logic [31:0] ir;
  logic [3:0]  dec_alu;
  logic        dec_illegal;
  logic        is_imm, is_load, is_store, is_branch, uses_imm;
  logic        retire, set_cause, timeout;
  logic [1:0]  next_cause;
  logic        unused_ir_bits;

  multicycle_alu_dec u_dec (
    .opcode   (ir[6:0]),
    .funct3   (ir[14:12]),
    .funct7_5 (ir[30]),
    .alu_ctrl (dec_alu),
    .illegal  (dec_illegal)
  );

  assign is_imm         = (ir[6:0] == OP_IMM);
  assign is_load        = (ir[6:0] == OP_LOAD);
  assign is_store       = (ir[6:0] == OP_STORE);
  assign is_branch      = (ir[6:0] == OP_BRANCH);
  assign uses_imm       = is_imm || is_load || is_store;
  assign trap           = (state == S_TRAP);
  assign unused_ir_bits = ^{ir[31], ir[29:15], ir[11:7]};

`ifdef MULTICYCLE_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] wait_cnt;

  assign timeout = (state == S_MEM) && !dmem_ready &&
                   (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // Count MEM cycles without dmem_ready; cleared whenever outside MEM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  wait_cnt <= '0;
    else if (state != S_MEM)  wait_cnt <= '0;
    else if (!dmem_ready)     wait_cnt <= wait_cnt + CNT_W'(1);
  end
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
  assign timeout = 1'b0;
`endif

  // State, instruction register, retire counter and trap cause.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IF;
      ir         <= '0;
      retired    <= '0;
      trap_cause <= CAUSE_NONE;
    end else begin
      state <= next_state;
      if (state == S_IF && imem_ready) ir <= instr;
      if (retire) retired <= retired + RET_W'(1);
      if (set_cause) trap_cause <= next_cause;
    end
  end

  // Next state and datapath controls decoded from state and ir.
  always_comb begin
    next_state = state;
    imem_req   = 1'b0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    ALUSrc     = 1'b0;
    MemToReg   = 1'b0;
    RegWrite   = 1'b0;
    loadPC     = 1'b0;
    PCSrc      = 1'b0;
    ALUCtrl    = 4'b0000;
    retire     = 1'b0;
    set_cause  = 1'b0;
    next_cause = CAUSE_NONE;
    case (state)
      S_IF: begin
        imem_req = !rst;
        if (imem_ready) next_state = S_ID;
      end
      S_ID: begin
        ALUSrc = uses_imm && !dec_illegal;
        if (dec_illegal) begin
          next_state = S_TRAP;
          set_cause  = 1'b1;
          next_cause = CAUSE_ILLEGAL;
        end else begin
          next_state = S_EX;
        end
      end
      S_EX: begin
        ALUCtrl = dec_alu;
        ALUSrc  = uses_imm;
        if (is_load || is_store) begin
          next_state = S_MEM;
        end else if (is_branch) begin
          loadPC     = 1'b1;
          PCSrc      = ir[12] ? !Zero : Zero;
          retire     = 1'b1;
          next_state = S_IF;
        end else begin
          next_state = S_WB;
        end
      end
      S_MEM: begin
        MemRead  = is_load;
        MemWrite = is_store;
        if (dmem_ready) begin
          if (is_store) begin
            loadPC     = 1'b1;
            retire     = 1'b1;
            next_state = S_IF;
          end else begin
            next_state = S_WB;
          end
        end else if (timeout) begin
          next_state = S_TRAP;
          set_cause  = 1'b1;
          next_cause = CAUSE_TIMEOUT;
        end
      end
      S_WB: begin
        RegWrite   = 1'b1;
        loadPC     = 1'b1;
        MemToReg   = is_load;
        retire     = 1'b1;
        next_state = S_IF;
      end
      S_TRAP: next_state = S_TRAP;
      default: next_state = S_IF;
    endcase
  end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Parametrised control unit for the multicycle RV32I core: fetches through a ready handshake, latches the instruction, decodes it and sequences the datapath through a variable-length IF/ID/EX/MEM/WB schedule. Non-memory instructions skip MEM and branches retire in EX. Memory stalls are handled with wait states, and illegal instructions trap. It sits beside the datapath, driving its ALUSrc/ALUCtrl/MemToReg/RegWrite/loadPC/PCSrc inputs and the instruction/data memory strobes.

## Interface
- TIMEOUT_CYCLES, 16, maximum MEM wait cycles before a timeout trap (used only with the timeout feature)
- RET_W, 32, width of the retired-instruction counter
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- instr  in  32  instruction word from instruction memory
- imem_ready  in  1  instruction word valid this cycle
- dmem_ready  in  1  data access completes this cycle
- Zero  in  1  ALU zero flag from datapath
- imem_req  out  1  fetch request
- MemRead / MemWrite  out  1 each  data memory strobes
- ALUSrc, MemToReg, RegWrite, loadPC, PCSrc  out  1 each  datapath controls
- ALUCtrl  out  4  ALU operation
- trap  out  1  sticky error flag
- trap_cause  out  2  01 = illegal instruction, 10 = memory timeout
- retired  out  RET_W  count of completed instructions

## Operation
- States: IF, ID, EX, MEM, WB, TRAP. ir is the internal instruction register.
- IF
  - imem_req=1.
  - When imem_ready=1 at the edge: ir<=instr, go to ID. Otherwise stay in IF.
- ID
  - Decode ir.
  - Unsupported opcode/funct: go to TRAP with cause 01. Otherwise go to EX.
  - ALUSrc=1 for I-type, LW and SW.
- EX
  - ALUCtrl codes: ADD 0010, SUB 0110, AND 0000, OR 0001, XOR 1010, SLT 0111, SLL 1001, SRL 1000, SRA 1100.
  - R-type and OP-IMM: code from funct3 plus instr[30].
  - LW/SW: ADD, ALUSrc=1. Next state is MEM.
  - BEQ/BNE: SUB, loadPC=1, PCSrc = Zero for BEQ, !Zero for BNE. The branch retires here and the next state is IF.
  - All other instructions: next state is WB.
- MEM
  - MemRead=1 for LW, MemWrite=1 for SW. Strobes are held until dmem_ready=1.
  - On dmem_ready, LW goes to WB.
  - On dmem_ready, SW asserts loadPC=1 with PCSrc=0, retires and goes to IF.
- WB
  - RegWrite=1, loadPC=1, PCSrc=0; MemToReg=1 only for LW. Retire, then go to IF.
- TRAP
  - Every control output is 0 and imem_req=0; trap=1.
  - The state is held until rst.
- Retire: retired increments by 1 and wraps from 2^RET_W−1 to 0.
- Supported instructions: ADD SUB AND OR XOR SLT SLL SRL SRA, ADDI XORI ORI ANDI SLTI SLLI SRLI SRAI, LW, SW, BEQ, BNE.

## Timing
- Reset values: state=IF, ir=0, retired=0, trap=0, trap_cause=00.
  - Decoded outputs are 0 in reset, except imem_req, which is 1 once IF is entered.
- Outputs are decoded from registered state and ir. Only three paths are combinational from inputs:
  - Zero → PCSrc in EX;
  - dmem_ready → loadPC in MEM for SW;
  - the retire pulse.
- Latency, zero-wait memories:
  - R/I: 4 cycles;
  - LW: 5 cycles;
  - SW: 4 cycles;
  - branch: 3 cycles.
  - Each imem_ready or dmem_ready wait cycle adds one cycle.
- Exactly one loadPC pulse per retired instruction.
- rst mid-instruction: the state returns to IF immediately and all strobes drop in the same cycle. An in-flight memory access is abandoned.
- imem_ready asserted outside IF is ignored.
- dmem_ready asserted outside MEM is ignored.

## Configuration
- MULTICYCLE_TIMEOUT_EN defined:
  - A wait counter resets on entry to MEM and increments each cycle dmem_ready=0.
  - When it reaches TIMEOUT_CYCLES, the next state is TRAP with cause 10.
- MULTICYCLE_TIMEOUT_EN undefined: MEM waits indefinitely, the counter logic is absent, and trap_cause 10 never occurs.

## Structure
- The package multicycle_pkg holds:
  - the state_t enum;
  - opcode constants (OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH);
  - the ALUCtrl code constants;
  - the trap_cause constants.
- One sub-module, multicycle_alu_dec: a combinational map from opcode/funct3/funct7[5] to ALUCtrl plus an illegal flag. ID and EX share it.

## Test plan
- ADD x3,x1,x2 (0x002081B3) with imem_ready=1: IF→ID→EX→WB.
  - ALUCtrl=0010 in EX.
  - RegWrite=1 and loadPC=1 in WB.
  - retired 0→1.
- LW (0x0000A183) with dmem_ready low for 3 cycles: MemRead held 4 cycles, then WB with MemToReg=1. Total 8 cycles.
- BEQ with Zero=1: EX asserts loadPC=1, PCSrc=1, then IF; there is no WB.
  - BNE with Zero=1: PCSrc=0.
- Opcode 0x7F: TRAP after ID, trap=1, trap_cause=01. Everything stays 0 through 10 further cycles with imem_ready pulsed.
- With MULTICYCLE_TIMEOUT_EN and TIMEOUT_CYCLES=4, SW with dmem_ready=0: trap_cause=10 after 4 MEM cycles.
  - The same test with the macro undefined: still in MEM after 100 cycles.
- rst asserted during LW MEM: MemRead drops immediately, state=IF, retired=0.
